pair_serializer: RTL

Upstream stimulus stage for the `bfm` datapath. Accepts one wide package of `PACKAGE_WIDTH` bits through a valid/ready handshake, then emits it as `NUM` consecutive (A, B) byte pairs, least-significant 16 bits first. Each pair is offered on a valid/ready handshake to the stage that drives `A_s`/`B_s` into `bfm`. This replaces free-running testbench shifting with a backpressure-aware, restartable serializer.

---
 rtl/pair_serializer_if.sv | 27 ++
 rtl/pair_serializer.sv | 120 ++++++++++++
 2 files changed

// File: rtl/pair_serializer_if.sv
// Handshake bundle for pair_serializer: package input side and pair output side.
// The slave modport is the serializer's view; master is the driving/observing side.
interface pair_serializer_if #(
  parameter int PACKAGE_WIDTH = 1600,
  parameter int NUM           = 100,
  parameter int CW            = $clog2(NUM + 1)
);
  logic [PACKAGE_WIDTH-1:0] pkg_i;
  logic                     pkg_valid_i;
  logic                     pkg_ready_o;
  logic [7:0]               a_o;
  logic [7:0]               b_o;
  logic                     pair_valid_o;
  logic                     pair_ready_i;
  logic [CW-1:0]            pair_cnt_o;
  logic                     done_o;

  modport slave (
    input  pkg_i, pkg_valid_i, pair_ready_i,
    output pkg_ready_o, a_o, b_o, pair_valid_o, pair_cnt_o, done_o
  );

  modport master (
    output pkg_i, pkg_valid_i, pair_ready_i,
    input  pkg_ready_o, a_o, b_o, pair_valid_o, pair_cnt_o, done_o
  );
endinterface

// File: rtl/pair_serializer.sv
// pair_serializer: accepts one wide package and emits it as NUM (A,B) byte
// pairs, least-significant 16 bits first, each pair on a valid/ready handshake.
// All outputs come straight from registers; nothing combinational from inputs.
module pair_serializer #(
  parameter int PACKAGE_WIDTH = 1600,
  parameter int NUM           = 100,
  parameter int CW            = $clog2(NUM + 1)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  pair_serializer_if.slave  bus
);

  // Only the low 16*NUM package bits are ever emitted.
  localparam int SW = 16 * NUM;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [SW-1:0] r_shreg;
  logic [CW-1:0] r_cnt;
  logic          r_pkg_ready;
  logic          r_pair_valid;
  logic          r_done;
  logic [7:0]    r_a;
  logic [7:0]    r_b;

  logic [SW-1:0] w_shreg_shifted;
  logic [SW-1:0] w_pkg_kept;
  logic          w_last;

  assign w_shreg_shifted = r_shreg >> 16;
  assign w_pkg_kept      = bus.pkg_i[SW-1:0];
  assign w_last          = (r_cnt == CW'(NUM - 1));

  // Bits above 16*NUM are dropped on load; fold them so they are visibly consumed.
  generate
    if (PACKAGE_WIDTH > SW) begin : g_discard
      logic w_unused_hi;
      assign w_unused_hi = ^bus.pkg_i[PACKAGE_WIDTH-1:SW];
    end
  endgenerate

  // Serializer FSM with registered outputs; A/B are preloaded with the next
  // pair so they change exactly on the accepting edge and hold during stalls.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state      <= S_IDLE;
      r_shreg      <= '0;
      r_cnt        <= '0;
      r_pkg_ready  <= 1'b1;
      r_pair_valid <= 1'b0;
      r_done       <= 1'b0;
      r_a          <= 8'h00;
      r_b          <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.pkg_valid_i) begin
            r_state      <= S_SEND;
            r_shreg      <= w_pkg_kept;
            r_cnt        <= '0;
            r_pkg_ready  <= 1'b0;
            r_pair_valid <= 1'b1;
            r_a          <= w_pkg_kept[7:0];
            r_b          <= w_pkg_kept[15:8];
          end
        end

        S_SEND: begin
          if (bus.pair_ready_i) begin
            r_shreg <= w_shreg_shifted;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
              r_state      <= S_DONE;
              r_pair_valid <= 1'b0;
              r_done       <= 1'b1;
              r_a          <= 8'h00;
              r_b          <= 8'h00;
            end else begin
              r_a <= w_shreg_shifted[7:0];
              r_b <= w_shreg_shifted[15:8];
            end
          end
        end

        S_DONE: begin
          r_state     <= S_IDLE;
          r_done      <= 1'b0;
          r_cnt       <= '0;
          r_pkg_ready <= 1'b1;
        end

        default: begin
          r_state      <= S_IDLE;
          r_shreg      <= '0;
          r_cnt        <= '0;
          r_pkg_ready  <= 1'b1;
          r_pair_valid <= 1'b0;
          r_done       <= 1'b0;
          r_a          <= 8'h00;
          r_b          <= 8'h00;
        end
      endcase
    end
  end

  assign bus.pkg_ready_o  = r_pkg_ready;
  assign bus.pair_valid_o = r_pair_valid;
  assign bus.a_o          = r_a;
  assign bus.b_o          = r_b;
  assign bus.pair_cnt_o   = r_cnt;
  assign bus.done_o       = r_done;

endmodule
